// File: rtl/pixel_stream_source_pkg.sv
// Shared constants and FSM encoding for the raster pixel source.
package pixel_stream_source_pkg;
   localparam int unsigned FRAME_WIDTH_DEF  = 640;
   localparam int unsigned FRAME_HEIGHT_DEF = 480;
   localparam int unsigned PIXEL_SIZE_DEF   = 24;
   localparam int unsigned HBLANK_DEF       = 16;
   localparam int unsigned COORD_W          = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_HBLANK,
      ST_DRAIN
   } state_t;
endpackage

// File: rtl/pixel_stream_source_if.sv
// Pixel stream handshake: en/x/y/data forward, ready backward.
interface pixel_stream_source_if
   import pixel_stream_source_pkg::*;
#(
   parameter int unsigned PIXEL_SIZE = PIXEL_SIZE_DEF
);
   logic                  en;
   logic [COORD_W-1:0]    x;
   logic [COORD_W-1:0]    y;
   logic [PIXEL_SIZE-1:0] data;
   logic                  ready;

   modport master (output en, x, y, data, input ready);
   modport slave  (input en, x, y, data, output ready);
endinterface

// File: rtl/pixel_stream_source_skid_fifo.sv
// Two-entry synchronous FIFO; the head is read straight from storage registers.
module skid_fifo #(
   parameter int unsigned DATA_WIDTH = 88
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [1:0]            o_count
);
   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_wptr;
   logic                  r_rptr;
   logic [1:0]            r_count;
   logic                  w_push;
   logic                  w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;
endmodule

// File: rtl/pixel_stream_source.sv
// Reads one frame in raster order from a 1-cycle-latency memory and streams it with
// x/y tags, horizontal blanking and credit-based backpressure into a 2-entry skid FIFO.
module pixel_stream_source
   import pixel_stream_source_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
   parameter int unsigned FRAME_HEIGHT = FRAME_HEIGHT_DEF,
   parameter int unsigned HBLANK       = HBLANK_DEF,
   parameter int unsigned ADDR_WIDTH   = 19,
   parameter int unsigned PIXEL_SIZE   = PIXEL_SIZE_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [PIXEL_SIZE-1:0] mem_data,
   output logic                  busy,
   output logic                  frame_done,
   pixel_stream_source_if.master pix
);
   localparam int unsigned TAG_W   = PIXEL_SIZE + 2 * COORD_W;
   localparam int unsigned HB_W    = (HBLANK > 1) ? $clog2(HBLANK) : 1;
   localparam int unsigned HB_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;

   state_t                r_state;
   logic [COORD_W-1:0]    r_rx;
   logic [COORD_W-1:0]    r_ry;
   logic [COORD_W-1:0]    r_tag_x;
   logic [COORD_W-1:0]    r_tag_y;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [HB_W-1:0]       r_hb_cnt;
   logic                  r_pend;
   logic                  r_frame_done;

   logic                  w_pop;
   logic                  w_issue;
   logic                  w_credit_ok;
   logic                  w_row_end;
   logic                  w_last_rd;
   logic                  w_last_xfer;
   logic                  w_full;
   logic                  w_empty;
   logic [1:0]            w_count;
   logic [2:0]            w_slots;
   logic [TAG_W-1:0]      w_head;

   assign w_pop = pix.en && pix.ready;

   // A pixel leaving this cycle frees its slot in time for a read issued now.
   assign w_slots     = {1'b0, w_count} + {2'b00, r_pend} - {2'b00, w_pop};
   assign w_credit_ok = !(w_full && !w_pop) && (w_slots < 3'd2);
   assign w_issue     = (r_state == ST_ACTIVE) && w_credit_ok;

   assign w_row_end   = (r_rx == COORD_W'(FRAME_WIDTH - 1));
   assign w_last_rd   = w_row_end && (r_ry == COORD_W'(FRAME_HEIGHT - 1));
   // In DRAIN every read is issued, so the final entry leaving with nothing in flight is the last pixel.
   assign w_last_xfer = w_pop && (r_state == ST_DRAIN) && (w_count == 2'd1) && !r_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_rx         <= '0;
         r_ry         <= '0;
         r_tag_x      <= '0;
         r_tag_y      <= '0;
         r_addr       <= '0;
         r_hb_cnt     <= '0;
         r_pend       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_last_xfer;
         r_pend       <= w_issue;
         if (w_issue) begin
            r_tag_x <= r_rx;
            r_tag_y <= r_ry;
         end
         case (r_state)
            ST_IDLE: begin
               // The frame_done cycle still counts as busy for start.
               if (start && !r_frame_done) begin
                  r_state <= ST_ACTIVE;
                  r_rx    <= '0;
                  r_ry    <= '0;
                  r_addr  <= '0;
               end
            end
            ST_ACTIVE: begin
               if (w_issue) begin
                  r_addr <= r_addr + ADDR_WIDTH'(1);
                  if (w_row_end) begin
                     r_rx <= '0;
                     if (w_last_rd) begin
                        r_state <= ST_DRAIN;
                     end else begin
                        r_ry <= r_ry + COORD_W'(1);
                        if (HBLANK > 0) begin
                           r_state  <= ST_HBLANK;
                           r_hb_cnt <= '0;
                        end
                     end
                  end else begin
                     r_rx <= r_rx + COORD_W'(1);
                  end
               end
            end
            ST_HBLANK: begin
               if (r_hb_cnt == HB_W'(HB_LAST)) r_state  <= ST_ACTIVE;
               else                            r_hb_cnt <= r_hb_cnt + HB_W'(1);
            end
            ST_DRAIN: begin
               if (w_last_xfer) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   skid_fifo #(.DATA_WIDTH(TAG_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_pend),
      .i_data  ({mem_data, r_tag_y, r_tag_x}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign mem_rd_en  = w_issue;
   assign mem_addr   = r_addr;
   assign busy       = (r_state != ST_IDLE) || !w_empty || r_pend;
   assign frame_done = r_frame_done;

   assign pix.en   = !w_empty;
   assign pix.x    = w_head[COORD_W-1:0];
   assign pix.y    = w_head[2*COORD_W-1:COORD_W];
   assign pix.data = w_head[TAG_W-1:2*COORD_W];
endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench: two instances (4x3 with 2 blanking cycles, 4x2 with none) fed by a memory model.
`timescale 1ns/1ps
module tb_pixel_stream_source;
   import pixel_stream_source_pkg::*;

   typedef struct {
      int         x;
      int         y;
      logic [23:0] d;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   logic        start_a = 1'b0;
   logic        rd_a;
   logic [3:0]  addr_a;
   logic [23:0] mdata_a = '0;
   logic        busy_a;
   logic        done_a;
   pixel_stream_source_if #(.PIXEL_SIZE(24)) pa ();

   logic        start_b = 1'b0;
   logic        rd_b;
   logic [2:0]  addr_b;
   logic [23:0] mdata_b = '0;
   logic        busy_b;
   logic        done_b;
   pixel_stream_source_if #(.PIXEL_SIZE(24)) pb ();

   pixel_stream_source #(.FRAME_WIDTH(4), .FRAME_HEIGHT(3), .HBLANK(2), .ADDR_WIDTH(4), .PIXEL_SIZE(24)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
      .mem_data(mdata_a), .busy(busy_a), .frame_done(done_a), .pix(pa));

   pixel_stream_source #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .HBLANK(0), .ADDR_WIDTH(3), .PIXEL_SIZE(24)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
      .mem_data(mdata_b), .busy(busy_b), .frame_done(done_b), .pix(pb));

   // Frame memory content: pixel at address a holds 0x100 + a.
   always @(posedge clk) begin
      if (rd_a) mdata_a <= 24'h100 + 24'(addr_a);
      if (rd_b) mdata_b <= 24'h100 + 24'(addr_b);
   end

   function automatic void push_frame(int w, int h);
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++)
            sb.push_back('{x: xx, y: yy, d: 24'(32'h100 + yy * w + xx)});
   endfunction

   task automatic test_reset();
      pa.ready = 1'b0;
      pb.ready = 1'b0;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({pa.en, rd_a, busy_a, done_a, pa.x, pa.y, pa.data, addr_a} !== '0) begin
         errors++;
         $display("FAIL reset_hold: en=%b rd=%b busy=%b x=%0d y=%0d data=%h, want all zero",
                  pa.en, rd_a, busy_a, pa.x, pa.y, pa.data);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({pa.en, rd_a, busy_a, done_a, pa.x, pa.y, pa.data, addr_a,
              pb.en, rd_b, busy_b, done_b, pb.x, pb.y, pb.data, addr_b} !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: A en=%b rd=%b busy=%b done=%b x=%0d y=%0d data=%h addr=%0d B en=%b rd=%b busy=%b, want all zero",
                     i, pa.en, rd_a, busy_a, done_a, pa.x, pa.y, pa.data, addr_a, pb.en, rd_b, busy_b);
         end
      end
   endtask

   task automatic test_basic();
      exp_t e;
      int   gap = 0;
      bit   seen_first = 0, done_seen = 0, prev_last = 0;
      sb.delete();
      push_frame(4, 3);
      pa.ready = 1'b1;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0; #1;
      checks++;
      if (rd_a !== 1'b1 || addr_a !== 4'd0 || pa.en !== 1'b0) begin
         errors++;
         $display("FAIL basic_first_read: rd=%b addr=%0d en=%b, want rd=1 addr=0 en=0", rd_a, addr_a, pa.en);
      end
      @(negedge clk); #1;
      checks++;
      if (pa.en !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency_early: en=%b, want 0", pa.en);
      end
      for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
         @(negedge clk); #1;
         if (cyc == 0) begin
            checks++;
            if (pa.en !== 1'b1) begin
               errors++;
               $display("FAIL basic_latency_en: en=%b, want 1", pa.en);
            end
         end
         checks++;
         if (done_a !== prev_last) begin
            errors++;
            $display("FAIL basic_frame_done cyc %0d: got %b want %b", cyc, done_a, prev_last);
         end
         if (done_a === 1'b1) begin
            done_seen = 1;
            checks++;
            if (busy_a !== 1'b0 || sb.size() != 0) begin
               errors++;
               $display("FAIL basic_busy_at_done: busy=%b left=%0d, want busy=0 left=0", busy_a, sb.size());
            end
         end
         prev_last = 0;
         if (pa.en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL basic_extra_pixel: got (%0d,%0d)=%h, want no pixel", pa.x, pa.y, pa.data);
            end else begin
               e = sb.pop_front();
               if (pa.x !== e.x || pa.y !== e.y || pa.data !== e.d) begin
                  errors++;
                  $display("FAIL basic_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", pa.x, pa.y, pa.data, e.x, e.y, e.d);
               end
               if (seen_first) begin
                  checks++;
                  if (gap != ((e.x == 0) ? 2 : 0)) begin
                     errors++;
                     $display("FAIL basic_gap before (%0d,%0d): got %0d idle want %0d", e.x, e.y, gap, (e.x == 0) ? 2 : 0);
                  end
               end
               seen_first = 1;
               gap        = 0;
               prev_last  = (sb.size() == 0);
            end
         end else if (seen_first) begin
            gap++;
         end
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL basic_timeout: frame_done not seen, %0d pixels missing", sb.size());
      end
      @(negedge clk); #1;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || pa.en !== 1'b0) begin
         errors++;
         $display("FAIL basic_after_done: done=%b busy=%b en=%b, want 0 0 0", done_a, busy_a, pa.en);
      end
   endtask

   task automatic test_backpressure();
      exp_t        e;
      int          issued = 0, xfers = 0;
      bit          held = 0, done_seen = 0, prev_last = 0, pop;
      logic [31:0] hx = '0, hy = '0;
      logic [23:0] hd = '0;
      sb.delete();
      push_frame(4, 3);
      @(negedge clk); start_a = 1'b1;
      for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
         @(negedge clk);
         start_a  = 1'b0;
         pa.ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         #1;
         pop = pa.en && pa.ready;
         if (held) begin
            checks++;
            if (pa.en !== 1'b1 || pa.x !== hx || pa.y !== hy || pa.data !== hd) begin
               errors++;
               $display("FAIL bp_stable: got en=%b (%0d,%0d)=%h want en=1 (%0d,%0d)=%h", pa.en, pa.x, pa.y, pa.data, hx, hy, hd);
            end
         end
         if (rd_a === 1'b1) begin
            checks++;
            if (issued - xfers - (pop ? 1 : 0) >= 2) begin
               errors++;
               $display("FAIL bp_credit: read issued with %0d outstanding, want < 2", issued - xfers - (pop ? 1 : 0));
            end
            issued++;
         end
         checks++;
         if (done_a !== prev_last) begin
            errors++;
            $display("FAIL bp_frame_done cyc %0d: got %b want %b", cyc, done_a, prev_last);
         end
         if (done_a === 1'b1) done_seen = 1;
         prev_last = 0;
         if (pop) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_pixel: got (%0d,%0d)=%h, want no pixel", pa.x, pa.y, pa.data);
            end else begin
               e = sb.pop_front();
               if (pa.x !== e.x || pa.y !== e.y || pa.data !== e.d) begin
                  errors++;
                  $display("FAIL bp_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", pa.x, pa.y, pa.data, e.x, e.y, e.d);
               end
               prev_last = (sb.size() == 0);
            end
            xfers++;
            held = 0;
         end else if (pa.en === 1'b1) begin
            held = 1;
            hx = pa.x; hy = pa.y; hd = pa.data;
         end else begin
            held = 0;
         end
      end
      checks++;
      if (!done_seen || xfers != 12 || issued != 12) begin
         errors++;
         $display("FAIL bp_totals: done=%0b xfers=%0d reads=%0d, want 1 12 12", done_seen, xfers, issued);
      end
      pa.ready = 1'b1;
   endtask

   task automatic test_zero_blank();
      exp_t e;
      bit   found = 0;
      sb.delete();
      push_frame(4, 2);
      pb.ready = 1'b1;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk); #1;
         found = (pb.en === 1'b1);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL zb_timeout: en never rose, want en within 10 cycles");
         return;
      end
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            @(negedge clk); #1;
         end
         e = sb.pop_front();
         checks++;
         if (pb.en !== 1'b1 || pb.x !== e.x || pb.y !== e.y || pb.data !== e.d) begin
            errors++;
            $display("FAIL zb_pixel %0d: got en=%b (%0d,%0d)=%h want en=1 (%0d,%0d)=%h", k, pb.en, pb.x, pb.y, pb.data, e.x, e.y, e.d);
         end
      end
      @(negedge clk); #1;
      checks++;
      if (done_b !== 1'b1 || pb.en !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL zb_done: done=%b en=%b busy=%b, want 1 0 0", done_b, pb.en, busy_b);
      end
   endtask

   task automatic test_spurious_start();
      exp_t e;
      int   frames = 0, after_done = 0;
      bit   prev_last = 0, extra = 0;
      sb.delete();
      push_frame(4, 3);
      push_frame(4, 3);
      pa.ready = 1'b1;
      @(negedge clk); start_a = 1'b1;
      for (int cyc = 0; cyc < 200 && frames < 2; cyc++) begin
         @(negedge clk); #1;
         start_a = 1'b0;
         checks++;
         if (done_a !== prev_last) begin
            errors++;
            $display("FAIL ss_frame_done cyc %0d: got %b want %b", cyc, done_a, prev_last);
         end
         if (after_done == 1) begin
            checks++;
            if (rd_a !== 1'b0 || busy_a !== 1'b0) begin
               errors++;
               $display("FAIL ss_start_in_done_cycle: rd=%b busy=%b, want 0 0", rd_a, busy_a);
            end
            start_a    = 1'b1;
            after_done = 2;
         end else if (after_done == 2) begin
            checks++;
            if (rd_a !== 1'b1 || addr_a !== 4'd0) begin
               errors++;
               $display("FAIL ss_relaunch: rd=%b addr=%0d, want 1 0", rd_a, addr_a);
            end
            after_done = 0;
         end
         if (done_a === 1'b1) begin
            frames++;
            if (frames == 1) begin
               start_a    = 1'b1;
               after_done = 1;
            end
         end
         if (cyc == 6) start_a = 1'b1;
         prev_last = 0;
         if (pa.en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL ss_extra_pixel: got (%0d,%0d)=%h, want no pixel", pa.x, pa.y, pa.data);
            end else begin
               e = sb.pop_front();
               if (pa.x !== e.x || pa.y !== e.y || pa.data !== e.d) begin
                  errors++;
                  $display("FAIL ss_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", pa.x, pa.y, pa.data, e.x, e.y, e.d);
               end
               prev_last = (sb.size() == 12) || (sb.size() == 0);
            end
         end
      end
      start_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (pa.en === 1'b1 || busy_a === 1'b1) extra = 1;
      end
      checks++;
      if (frames != 2 || sb.size() != 0 || extra) begin
         errors++;
         $display("FAIL ss_frame_count: frames=%0d left=%0d third_frame=%0b, want 2 0 0", frames, sb.size(), extra);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   found = 0, done_seen = 0, stale = 0;
      int   xfers = 0;
      pa.ready = 1'b1;
      @(negedge clk); start_a = 1'b1;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk); #1;
         start_a = 1'b0;
         if (pa.en === 1'b1 && pa.x == 2 && pa.y == 1) begin
            found    = 1;
            pa.ready = 1'b0;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rm_reach: pixel (2,1) never presented, want it within 60 cycles");
      end
      repeat (2) begin
         @(negedge clk); #1;
         checks++;
         if (pa.en !== 1'b1 || pa.x !== 2 || pa.y !== 1 || pa.data !== 24'h106) begin
            errors++;
            $display("FAIL rm_hold: got en=%b (%0d,%0d)=%h want en=1 (2,1)=106", pa.en, pa.x, pa.y, pa.data);
         end
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({pa.en, pa.x, pa.y, pa.data, rd_a, busy_a, done_a, addr_a} !== '0) begin
         errors++;
         $display("FAIL rm_async: en=%b x=%0d y=%0d data=%h rd=%b busy=%b, want all zero", pa.en, pa.x, pa.y, pa.data, rd_a, busy_a);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0; pa.ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (pa.en === 1'b1 || busy_a === 1'b1) stale = 1;
      end
      checks++;
      if (stale) begin
         errors++;
         $display("FAIL rm_stale: output activity after reset without start, want none");
      end
      sb.delete();
      push_frame(4, 3);
      start_a = 1'b1;
      for (int cyc = 0; cyc < 80 && !done_seen; cyc++) begin
         @(negedge clk); #1;
         start_a = 1'b0;
         if (done_a === 1'b1) done_seen = 1;
         if (pa.en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rm_extra_pixel: got (%0d,%0d)=%h, want no pixel", pa.x, pa.y, pa.data);
            end else begin
               e = sb.pop_front();
               if (pa.x !== e.x || pa.y !== e.y || pa.data !== e.d) begin
                  errors++;
                  $display("FAIL rm_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", pa.x, pa.y, pa.data, e.x, e.y, e.d);
               end
            end
            xfers++;
         end
      end
      checks++;
      if (!done_seen || xfers != 12) begin
         errors++;
         $display("FAIL rm_restart_frame: done=%0b xfers=%0d, want 1 12", done_seen, xfers);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_blank();
      test_spurious_start();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
